// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit loads/stores as two 16-bit SRAM half-word transfers with
// per-half wait states, upstream freeze while busy, and a registered MEM->WB stage.
module mem_stage_sram #(
  parameter int BIT_NUMBER  = 32,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_BASE    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [BIT_NUMBER-1:0]  alu_result_in,
  input  logic [BIT_NUMBER-1:0]  val_rm_in,
  input  logic [3:0]             dest_in,
  output logic                   freeze,
  output logic                   wb_en,
  output logic                   mem_r_en,
  output logic [BIT_NUMBER-1:0]  alu_result,
  output logic [BIT_NUMBER-1:0]  mem_data,
  output logic [3:0]             dest,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic                    r_wr;
  logic [SRAM_ADDR_W-1:0]  r_sram_addr;
  logic [BIT_NUMBER-1:0]   r_rd_latch;
  logic                    w_req;
  logic                    w_last;
  logic                    w_phase;
  logic                    w_freeze;

  // SRAM word index relative to MEM_BASE; bits [1:0] and out-of-range high bits drop out.
  function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [BIT_NUMBER-1:0] byte_addr);
    logic [BIT_NUMBER-1:0] diff;
    diff = byte_addr - BIT_NUMBER'(MEM_BASE);
    return diff[SRAM_ADDR_W:2];
  endfunction

  assign w_req  = mem_r_en_in | mem_w_en_in;
  assign w_last = (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req)  w_next = S_LO;
      S_LO:    if (w_last) w_next = S_HI;
      S_HI:    if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_phase     = (r_state == S_LO) || (r_state == S_HI);
    w_freeze    = !rst && w_req && (r_state != S_DONE);
    sram_we_n   = !(r_wr && w_phase);
    sram_dq_oe  = r_wr && w_phase;
    sram_dq_out = 16'h0;
    if (r_wr && r_state == S_LO) sram_dq_out = val_rm_in[15:0];
    if (r_wr && r_state == S_HI) sram_dq_out = val_rm_in[31:16];
  end

  // Access bookkeeping: wait counter, direction, half-word address, read latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_sram_addr <= '0;
      r_rd_latch  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_cnt       <= LP_CNT_INIT;
          r_wr        <= mem_w_en_in;
          r_sram_addr <= {word_index(alu_result_in), 1'b0};
        end
        S_LO: if (w_last) begin
          r_cnt          <= LP_CNT_INIT;
          r_sram_addr[0] <= 1'b1;
          if (!r_wr) r_rd_latch[15:0] <= sram_dq_in;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_HI: if (w_last) begin
          if (!r_wr) r_rd_latch[31:16] <= sram_dq_in;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // MEM->WB register; a frozen edge drops wb_en so WB sees a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      alu_result <= '0;
      mem_data   <= '0;
      dest       <= 4'd0;
    end else if (w_freeze) begin
      wb_en <= 1'b0;
    end else begin
      wb_en      <= wb_en_in;
      mem_r_en   <= mem_r_en_in;
      alu_result <= alu_result_in;
      mem_data   <= r_rd_latch;
      dest       <= dest_in;
    end
  end

  assign freeze    = w_freeze;
  assign sram_addr = r_sram_addr;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: table of ALU/load/store vectors against a
// small SRAM model, plus back-to-back and reset-mid-access sequences.
module tb_mem_stage_sram;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_result_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        freeze, wb_en, mem_r_en;
  logic [31:0] alu_result, mem_data;
  logic [3:0]  dest;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_sram #(.BIT_NUMBER(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(W), .MEM_BASE(1024)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .freeze(freeze), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .alu_result(alu_result), .mem_data(mem_data), .dest(dest),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  // SRAM model, low 8 address bits decoded
  logic [15:0] sram_mem [256];
  assign sram_dq_in = sram_mem[sram_addr[7:0]];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_out;

  typedef struct {
    logic        wb;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] val;
    logic [3:0]  dst;
    int          exp_frz;
    logic [17:0] exp_addr;
    logic [31:0] exp_mem_data;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dst);
    wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
    alu_result_in = alu; val_rm_in = val; dest_in = dst;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int  c;
    int  nf;
    bit  done;
    logic hi;
    drive(v.wb, v.rd, v.wr, v.alu, v.val, v.dst);
    nf = 0;
    done = 1'b0;
    for (c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (freeze) begin
        nf++;
        if (c >= 1) begin
          hi = (c > W);
          chk({tag, " wb_bubble"}, {31'b0, wb_en}, 32'd0);
          chk({tag, " sram_addr"}, {14'b0, sram_addr}, {14'b0, v.exp_addr | {17'b0, hi}});
          if (v.wr) begin
            chk({tag, " we_n"}, {31'b0, sram_we_n}, 32'd0);
            chk({tag, " dq_oe"}, {31'b0, sram_dq_oe}, 32'd1);
            chk({tag, " dq_out"}, {16'b0, sram_dq_out}, {16'b0, hi ? v.val[31:16] : v.val[15:0]});
          end else begin
            chk({tag, " we_n"}, {31'b0, sram_we_n}, 32'd1);
            chk({tag, " dq_oe"}, {31'b0, sram_dq_oe}, 32'd0);
          end
        end
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
        chk({tag, " idle_we_n"}, {31'b0, sram_we_n}, 32'd1);
      end
    end
    if (!done) chk({tag, " timeout"}, 32'd1, 32'd0);
    chk({tag, " freeze_cycles"}, nf, v.exp_frz);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    chk({tag, " wb_en"}, {31'b0, wb_en}, {31'b0, v.wb});
    chk({tag, " mem_r_en"}, {31'b0, mem_r_en}, {31'b0, v.rd});
    chk({tag, " alu_result"}, alu_result, v.alu);
    chk({tag, " dest"}, {28'b0, dest}, {28'b0, v.dst});
    chk({tag, " mem_data"}, mem_data, v.exp_mem_data);
  endtask

  logic [12:0] frz_pat;
  logic [12:0] wb_pat;

  initial begin
    //           wb    rd    wr    alu           val           dst  frz addr      mem_data
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,        4'd5,  0, 18'h0,     32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'd1028,      32'hDEAD_BEEF, 4'd0,  5, 18'h2,     32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'd1028,      32'h0,        4'd7,  5, 18'h2,     32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        4'd15, 0, 18'h0,     32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'd1020,      32'h0BAD_F00D, 4'd0,  5, 18'h3FFFE, 32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'd1020,      32'h0,        4'd3,  5, 18'h3FFFE, 32'h0BAD_F00D};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'd1032,      32'h1234_5678, 4'd0,  5, 18'h4,     32'h0BAD_F00D};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 32'd1035,      32'h0,        4'd9,  5, 18'h4,     32'h1234_5678};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst freeze", {31'b0, freeze}, 32'd0);
    chk("rst wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst mem_r_en", {31'b0, mem_r_en}, 32'd0);
    chk("rst alu_result", alu_result, 32'd0);
    chk("rst mem_data", mem_data, 32'd0);
    chk("rst dest", {28'b0, dest}, 32'd0);
    chk("rst sram_addr", {14'b0, sram_addr}, 32'd0);
    chk("rst dq_out", {16'b0, sram_dq_out}, 32'd0);
    chk("rst dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rst we_n", {31'b0, sram_we_n}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back load then store: freeze windows 0..4 and 6..10, DONE at 5 and 11
    frz_pat = 13'b0_0111_1101_1111;
    wb_pat  = 13'b0_0000_0100_0000;
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd2);
    for (int c = 0; c < 13; c++) begin
      if (c == 6)  drive(1'b0, 1'b0, 1'b1, 32'd1044, 32'h55AA_33CC, 4'd4);
      if (c == 12) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      @(negedge clk);
      chk($sformatf("b2b freeze c%0d", c), {31'b0, freeze}, {31'b0, frz_pat[c]});
      if (c >= 1) chk($sformatf("b2b wb_en c%0d", c), {31'b0, wb_en}, {31'b0, wb_pat[c]});
      if (c == 6) chk("b2b load data", mem_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    chk("b2b store hi half", {16'b0, sram_mem[8'd11]}, 32'h0000_55AA);

    // Reset asserted during the HI half of a store
    drive(1'b1, 1'b0, 1'b1, 32'd1028, 32'hCAFE_BABE, 4'd6);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst pre we_n", {31'b0, sram_we_n}, 32'd0);
    chk("midrst pre addr", {14'b0, sram_addr}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst freeze", {31'b0, freeze}, 32'd0);
    chk("midrst we_n", {31'b0, sram_we_n}, 32'd1);
    chk("midrst dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("midrst wb_en", {31'b0, wb_en}, 32'd0);
    chk("midrst mem_r_en", {31'b0, mem_r_en}, 32'd0);
    chk("midrst alu_result", alu_result, 32'd0);
    chk("midrst mem_data", mem_data, 32'd0);
    chk("midrst dest", {28'b0, dest}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst freeze", {31'b0, freeze}, 32'd0);
    chk("postrst we_n", {31'b0, sram_we_n}, 32'd1);
    chk("postrst wb_en", {31'b0, wb_en}, 32'd0);
    chk("postrst mem_data", mem_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
